dds_sweep_ctrl: RTL

Frequency-sweep scheduler for the quarter-wave-ROM DDS core. It accepts a sweep configuration (start/stop FCW, step, dwell, mode) over a valid/ready port and sequences the DDS FCW input through a linear chirp: single-shot, repeating saw, or continuous up/down triangle. It holds the DDS in reset while idle and flags when DDS output samples belong to an active sweep.

---
 rtl/dds_ctrl_pkg.sv | 22 ++
 rtl/dds_valid_dly.sv | 34 +++
 rtl/dds_sweep_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS frequency-sweep controller.
// Sweep states, mode encodings and the default DDS pipeline latency.
package dds_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_REPEAT = 2'b01;
   localparam logic [1:0] MODE_UPDOWN = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   localparam int DDS_LAT_DEFAULT = 4;

   function automatic logic mode_ok(input logic [1:0] mode);
      return mode != MODE_RSVD;
   endfunction

endpackage

// File: rtl/dds_valid_dly.sv
// Fixed-depth delay line for the "sample belongs to sweep" flag.
// A synchronous flush clears every stage so an aborted sweep stops flagging at once.
module dds_valid_dly #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (flush) begin
         sr_d = '0;
      end else begin
         sr_d = (sr_q << 1) | DEPTH'(din);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear-chirp scheduler driving the DDS FCW: single, repeating saw or up/down triangle.
// Holds the DDS in reset outside RUN and tags DDS output samples of the active sweep.
module dds_sweep_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int FCW_W   = 15,
   parameter int DWELL_W = 16,
   parameter int DDS_LAT = DDS_LAT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [FCW_W-1:0]   cfg_start_fcw,
   input  logic [FCW_W-1:0]   cfg_stop_fcw,
   input  logic [FCW_W-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   output logic               cfg_err,
   input  logic               start,
   input  logic               abort,
   output logic [FCW_W-1:0]   fcw_out,
   output logic               dds_rst,
   output logic               hop,
   output logic               sweep_wrap,
   output logic               busy,
   output logic               done,
   output logic               sample_valid
);

   state_e               state_q, state_d;
   logic [FCW_W-1:0]     start_q, start_d;
   logic [FCW_W-1:0]     stop_q, stop_d;
   logic [FCW_W-1:0]     step_q, step_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [1:0]           mode_q, mode_d;
   logic                 loaded_q, loaded_d;
   logic [FCW_W-1:0]     fcw_q, fcw_d;
   logic                 dir_dn_q, dir_dn_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic                 hop_q, hop_d;
   logic                 wrap_q, wrap_d;
   logic                 err_q, err_d;

   logic                 cfg_ok;
   logic                 cfg_acc;
   logic                 run_now;
   logic [FCW_W:0]       up_sum;
   logic signed [FCW_W:0] dn_diff;
   logic signed [FCW_W:0] start_s;

   // One extra bit on both ramps so the FCW can never wrap past the bounds.
   function automatic logic [FCW_W-1:0] clamp_hi(input logic [FCW_W:0] v,
                                                 input logic [FCW_W-1:0] hi);
      return (v > {1'b0, hi}) ? hi : v[FCW_W-1:0];
   endfunction

   function automatic logic [FCW_W-1:0] clamp_lo(input logic signed [FCW_W:0] v,
                                                 input logic signed [FCW_W:0] lo);
      return (v < lo) ? lo[FCW_W-1:0] : v[FCW_W-1:0];
   endfunction

   assign cfg_ok  = (cfg_start_fcw <= cfg_stop_fcw) && (cfg_step != '0) && mode_ok(cfg_mode);
   assign cfg_acc = cfg_valid && (state_q == IDLE) && cfg_ok;
   assign up_sum  = {1'b0, fcw_q} + {1'b0, step_q};
   assign dn_diff = $signed({1'b0, fcw_q}) - $signed({1'b0, step_q});
   assign start_s = $signed({1'b0, start_q});
   assign run_now = (state_q == RUN);

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      mode_d   = mode_q;
      loaded_d = loaded_q;
      fcw_d    = fcw_q;
      dir_dn_d = dir_dn_q;
      cnt_d    = cnt_q;
      hop_d    = 1'b0;
      wrap_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               if (cfg_ok) begin
                  start_d  = cfg_start_fcw;
                  stop_d   = cfg_stop_fcw;
                  step_d   = cfg_step;
                  dwell_d  = cfg_dwell;
                  mode_d   = cfg_mode;
                  loaded_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            // A config accepted in the same cycle as start takes effect immediately.
            if (start && (loaded_q || cfg_acc)) begin
               state_d  = RUN;
               fcw_d    = cfg_acc ? cfg_start_fcw : start_q;
               dir_dn_d = 1'b0;
               cnt_d    = '0;
               hop_d    = 1'b1;
            end
         end

         RUN: begin
            if (cnt_q != dwell_q) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (!dir_dn_q) begin
                  if (up_sum <= {1'b0, stop_q}) begin
                     fcw_d = up_sum[FCW_W-1:0];
                     hop_d = 1'b1;
                  end else if (mode_q == MODE_SINGLE) begin
                     state_d = DONE;
                     fcw_d   = '0;
                  end else if (mode_q == MODE_REPEAT) begin
                     fcw_d  = start_q;
                     hop_d  = 1'b1;
                     wrap_d = 1'b1;
                  end else begin
                     dir_dn_d = 1'b1;
                     fcw_d    = clamp_lo(dn_diff, start_s);
                     hop_d    = 1'b1;
                     wrap_d   = 1'b1;
                  end
               end else begin
                  if (dn_diff >= start_s) begin
                     fcw_d = dn_diff[FCW_W-1:0];
                     hop_d = 1'b1;
                  end else begin
                     dir_dn_d = 1'b0;
                     fcw_d    = clamp_hi(up_sum, stop_q);
                     hop_d    = 1'b1;
                     wrap_d   = 1'b1;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         state_d  = IDLE;
         fcw_d    = '0;
         dir_dn_d = 1'b0;
         cnt_d    = '0;
         hop_d    = 1'b0;
         wrap_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         start_q  <= '0;
         stop_q   <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         mode_q   <= '0;
         loaded_q <= 1'b0;
         fcw_q    <= '0;
         dir_dn_q <= 1'b0;
         cnt_q    <= '0;
         hop_q    <= 1'b0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         step_q   <= step_d;
         dwell_q  <= dwell_d;
         mode_q   <= mode_d;
         loaded_q <= loaded_d;
         fcw_q    <= fcw_d;
         dir_dn_q <= dir_dn_d;
         cnt_q    <= cnt_d;
         hop_q    <= hop_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
      end
   end

   dds_valid_dly #(
      .DEPTH (DDS_LAT)
   ) u_valid_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .din   (run_now),
      .dout  (sample_valid)
   );

   assign cfg_ready  = (state_q == IDLE);
   assign busy       = run_now;
   assign done       = (state_q == DONE);
   assign dds_rst    = !run_now;
   assign fcw_out    = fcw_q;
   assign hop        = hop_q;
   assign sweep_wrap = wrap_q;
   assign cfg_err    = err_q;

endmodule
